// File: rtl/busarb_pkg.sv
// Shared definitions for the round-robin bus arbiter: state codes, grant width and
// the round-robin successor scan.
package busarb_pkg;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_ARB   = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_XFER  = 2'd3;

  localparam int unsigned MAX_CORES = 16;

  function automatic int unsigned calc_gw(input int unsigned ncores);
    int unsigned w;
    w = (ncores <= 2) ? 1 : $clog2(ncores);
    return w;
  endfunction

  // First requester after cur, wrapping mod ncores; cur itself is the last slot
  // examined. With no requester the grant simply advances by one.
  function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] cur,
                                         input int unsigned ncores);
    logic [3:0] nxt;
    logic [3:0] idx;
    logic       found;
    nxt   = 4'((32'(cur) + 1) % ncores);
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_CORES; k++) begin
      idx = 4'((32'(cur) + k) % ncores);
      if (!found && (k <= ncores) && req[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bus_port_mux.sv
// Grant-indexed steering: owner's bus onto the shared bus, shared return fanned back
// to the owner while every other core sees its idle value.
module bus_port_mux #(
  parameter int unsigned NCORES = 2,
  parameter int unsigned DW     = 1,
  parameter int unsigned GW     = 1
) (
  input  logic [GW-1:0]        grant_i,
  input  logic [NCORES*DW-1:0] core_bus_i,
  input  logic [DW-1:0]        ret_i,
  input  logic [DW-1:0]        ret_idle_i,
  output logic [DW-1:0]        shared_o,
  output logic [NCORES*DW-1:0] core_ret_o
);

  always_comb begin
    shared_o   = '0;
    core_ret_o = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (GW'(i) == grant_i) begin
        shared_o               = core_bus_i[i*DW +: DW];
        core_ret_o[i*DW +: DW] = ret_i;
      end else begin
        core_ret_o[i*DW +: DW] = ret_idle_i;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin owner selection for the shared memory/DRAM/CLINT/PLIC bus; ownership is held
// across a whole DRAM transaction. Optional watchdog: define BUSARB_WATCHDOG_EN.
module rr_bus_arbiter
  import busarb_pkg::*;
#(
  parameter int unsigned NCORES    = 2,
  parameter int unsigned GW        = calc_gw(NCORES),
  parameter int unsigned IDLE_ROT  = 3,
  parameter int unsigned WD_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              w_init_done,
  input  logic              w_tx_ready,
  input  logic              w_tlb_busy,
  input  logic              w_dram_busy,
  input  logic [NCORES-1:0] bus_req,
  output logic [GW-1:0]     w_grant,
  output logic              w_grant_chg,
  output logic [NCORES-1:0] bus_dram_busy,
  output logic              w_wd_err
);

  localparam int unsigned      IW       = $clog2(IDLE_ROT + 1);
  localparam logic [IW-1:0]    IDLE_MAX = IW'(IDLE_ROT);

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          busy_q, busy_d;
  logic          chg_q, chg_d;
  logic [GW-1:0] next_grant;
  logic          owner_req;
  logic          ok;

`ifdef BUSARB_WATCHDOG_EN
  localparam int unsigned   WW      = $clog2(WD_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WD_CYCLES - 1);
  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic          wd_err_q, wd_err_d;
`endif

  bus_port_mux #(
    .NCORES (NCORES),
    .DW     (1),
    .GW     (GW)
  ) u_port_mux (
    .grant_i    (grant_q),
    .core_bus_i (bus_req),
    .ret_i      (busy_q),
    .ret_idle_i (1'b1),
    .shared_o   (owner_req),
    .core_ret_o (bus_dram_busy)
  );

  assign ok         = !w_tlb_busy && !w_dram_busy && w_tx_ready;
  assign next_grant = GW'(rr_next(16'(bus_req), 4'(grant_q), NCORES));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idle_d  = idle_q;
    busy_d  = busy_q;
    chg_d   = chg_q;
`ifdef BUSARB_WATCHDOG_EN
    wd_cnt_d = wd_cnt_q;
    wd_err_d = wd_err_q;
`endif
    if (w_init_done) begin
      chg_d = 1'b0;
      case (state_q)
        S_BOOT: begin
          busy_d = w_dram_busy;
          if (w_dram_busy) state_d = S_ARB;
        end
        S_ARB: begin
          busy_d = w_dram_busy;
          if (ok && (idle_q < IDLE_MAX)) idle_d = idle_q + 1'b1;
          if (ok && ((|bus_req) || (idle_q >= IDLE_MAX))) begin
            grant_d = next_grant;
            chg_d   = (next_grant != grant_q);
            busy_d  = 1'b1;
            state_d = S_START;
          end
        end
        S_START: begin
          if (w_dram_busy || !owner_req) state_d = S_XFER;
        end
        default: begin
          busy_d = w_dram_busy;
          idle_d = '0;
          if (!w_dram_busy) state_d = S_ARB;
        end
      endcase
`ifdef BUSARB_WATCHDOG_EN
      // Stuck transaction: release the bus so the other cores can make progress.
      if ((state_q == S_START) || (state_q == S_XFER)) begin
        if (wd_cnt_q >= WD_LAST) begin
          wd_err_d = 1'b1;
          wd_cnt_d = '0;
          state_d  = S_ARB;
          busy_d   = 1'b0;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end else begin
        wd_cnt_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_BOOT;
      grant_q <= '0;
      idle_q  <= '0;
      busy_q  <= 1'b1;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idle_q  <= idle_d;
      busy_q  <= busy_d;
      chg_q   <= chg_d;
    end
  end

`ifdef BUSARB_WATCHDOG_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign w_wd_err = wd_err_q;
`else
  assign w_wd_err = 1'b0;
`endif

  assign w_grant     = grant_q;
  assign w_grant_chg = chg_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter (4 cores) against a cycle-level behavioural model.
module tb_rr_bus_arbiter;

  localparam int NC = 4;
  localparam int IR = 3;
  localparam int WD = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          w_init_done, w_tx_ready, w_tlb_busy, w_dram_busy;
  logic [NC-1:0] bus_req;
  logic [1:0]    w_grant;
  logic          w_grant_chg;
  logic [NC-1:0] bus_dram_busy;
  logic          w_wd_err;

  int total = 0;
  int bad   = 0;

  // Model: booted / in a transaction / transfer seen, owner, idle count, owner busy.
  bit       m_booted, m_in_txn, m_started, m_busy, m_chg, m_err;
  int       m_owner, m_idle, m_wd;

  always #5 CLK = ~CLK;

  rr_bus_arbiter #(
    .NCORES    (NC),
    .IDLE_ROT  (IR),
    .WD_CYCLES (WD)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .w_init_done   (w_init_done),
    .w_tx_ready    (w_tx_ready),
    .w_tlb_busy    (w_tlb_busy),
    .w_dram_busy   (w_dram_busy),
    .bus_req       (bus_req),
    .w_grant       (w_grant),
    .w_grant_chg   (w_grant_chg),
    .bus_dram_busy (bus_dram_busy),
    .w_wd_err      (w_wd_err)
  );

  // Requester at the smallest forward distance from the owner; owner itself is farthest.
  function automatic int pick_next(input logic [NC-1:0] req, input int own);
    int best  = -1;
    int bestd = NC + 1;
    for (int i = 0; i < NC; i++) begin
      if (req[i]) begin
        int d = (i - own - 1 + 2 * NC) % NC;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return (best < 0) ? (own + 1) % NC : best;
  endfunction

  task automatic model_edge();
    bit ok, was_txn, any_req;
    int nxt;
    if (RST) begin
      m_booted = 0; m_in_txn = 0; m_started = 0; m_busy = 1; m_chg = 0;
      m_err = 0; m_owner = 0; m_idle = 0; m_wd = 0;
      return;
    end
    if (!w_init_done) return;
    ok      = !w_tlb_busy && !w_dram_busy && w_tx_ready;
    any_req = (bus_req != '0);
    was_txn = m_booted && m_in_txn;
    m_chg   = 0;
    if (!m_booted) begin
      m_busy = w_dram_busy;
      if (w_dram_busy) m_booted = 1;
    end else if (!m_in_txn) begin
      m_busy = w_dram_busy;
      if (ok && (any_req || m_idle >= IR)) begin
        nxt       = pick_next(bus_req, m_owner);
        m_chg     = (nxt != m_owner);
        m_owner   = nxt;
        m_busy    = 1;
        m_in_txn  = 1;
        m_started = 0;
      end
      if (ok && m_idle < IR) m_idle++;
    end else if (!m_started) begin
      if (w_dram_busy || !bus_req[m_owner]) m_started = 1;
    end else begin
      m_busy = w_dram_busy;
      m_idle = 0;
      if (!w_dram_busy) m_in_txn = 0;
    end
`ifdef BUSARB_WATCHDOG_EN
    if (was_txn) begin
      if (m_wd + 1 >= WD) begin
        m_err = 1; m_in_txn = 0; m_busy = 0; m_wd = 0;
      end else begin
        m_wd++;
      end
    end else begin
      m_wd = 0;
    end
`else
    if (was_txn) m_wd = 0;
`endif
  endtask

  task automatic check_model();
    logic [NC-1:0] exp_busy;
    for (int i = 0; i < NC; i++) exp_busy[i] = (i == m_owner) ? m_busy : 1'b1;
    total++;
    assert (w_grant === 2'(m_owner)) else begin
      bad++; $error("FAIL grant: got %0d want %0d", w_grant, m_owner);
    end
    total++;
    assert (w_grant_chg === m_chg) else begin
      bad++; $error("FAIL grant_chg: got %b want %b", w_grant_chg, m_chg);
    end
    total++;
    assert (bus_dram_busy === exp_busy) else begin
      bad++; $error("FAIL dram_busy: got %b want %b", bus_dram_busy, exp_busy);
    end
    total++;
    assert (w_wd_err === m_err) else begin
      bad++; $error("FAIL wd_err: got %b want %b", w_wd_err, m_err);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    int rot;
    int n;
    RST = 1; w_init_done = 0; w_tx_ready = 1; w_tlb_busy = 0; w_dram_busy = 0; bus_req = '0;
    step(); step();
    total++;
    assert (w_grant === 2'd0 && w_grant_chg === 1'b0 && bus_dram_busy === 4'hF) else begin
      bad++; $error("FAIL reset: got g=%0d c=%b b=%b want g=0 c=0 b=1111",
                    w_grant, w_grant_chg, bus_dram_busy);
    end
    RST = 0; step();
    w_init_done = 1; w_dram_busy = 1; step();

    // Only core 2 requests: one-cycle grant, single change pulse
    w_dram_busy = 0; bus_req = 4'b0100; step();
    total++;
    assert (w_grant === 2'd2 && w_grant_chg === 1'b1) else begin
      bad++; $error("FAIL first_grant: got g=%0d c=%b want g=2 c=1", w_grant, w_grant_chg);
    end
    step();
    total++;
    assert (w_grant_chg === 1'b0) else begin
      bad++; $error("FAIL chg_pulse: got %b want 0", w_grant_chg);
    end

    // Long transfer: owner held, all non-owners busy
    w_dram_busy = 1; bus_req = 4'b1011;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      assert (w_grant === 2'd2 && bus_dram_busy === 4'hF) else begin
        bad++; $error("FAIL xfer_hold: got g=%0d b=%b want g=2 b=1111", w_grant, bus_dram_busy);
      end
    end
    w_dram_busy = 0; bus_req = '0; step();

    // Idle rotation: 4 arb cycles + start + xfer per hop
    rot = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (w_grant_chg) rot++;
    end
    total++;
    assert (rot === 5) else begin
      bad++; $error("FAIL idle_rot: got %0d want 5", rot);
    end

    // Blocked by page walk, then by UART
    for (int pass = 0; pass < 2; pass++) begin
      bus_req = '0;
      if (pass == 0) w_tlb_busy = 1; else w_tx_ready = 0;
      step(); step(); step();
      bus_req = 4'b0110;
      for (int i = 0; i < 8; i++) begin
        step();
        total++;
        assert (w_grant_chg === 1'b0 && w_grant === 2'(m_owner)) else begin
          bad++; $error("FAIL blocked: got c=%b g=%0d want c=0 g=%0d",
                        w_grant_chg, w_grant, m_owner);
        end
      end
      w_tlb_busy = 0; w_tx_ready = 1; step();
      total++;
      assert (w_grant_chg === 1'b1) else begin
        bad++; $error("FAIL release: got %b want 1", w_grant_chg);
      end
      bus_req = '0; step(); step();
    end

    // Reset in the middle of a transfer
    bus_req = 4'b1000; w_dram_busy = 1; step(); step();
    RST = 1; step();
    total++;
    assert (w_grant === 2'd0 && bus_dram_busy === 4'hF && w_grant_chg === 1'b0) else begin
      bad++; $error("FAIL mid_rst: got g=%0d b=%b c=%b want g=0 b=1111 c=0",
                    w_grant, bus_dram_busy, w_grant_chg);
    end
    RST = 0; w_dram_busy = 1; step();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus_req     = 4'($urandom);
      w_dram_busy = ($urandom % 3 == 0);
      w_tlb_busy  = ($urandom % 8 == 0);
      w_tx_ready  = ($urandom % 8 != 0);
      w_init_done = ($urandom % 32 != 0);
      step();
    end

`ifdef BUSARB_WATCHDOG_EN
    RST = 1; w_init_done = 1; w_tlb_busy = 0; w_tx_ready = 1; bus_req = '0; w_dram_busy = 0;
    step();
    RST = 0; w_dram_busy = 1; step();
    w_dram_busy = 0; bus_req = 4'b0010; step();
    w_dram_busy = 1;
    n = 0;
    while (!w_wd_err && n < 40) begin
      step();
      n++;
    end
    total++;
    assert (w_wd_err === 1'b1 && n === WD) else begin
      bad++; $error("FAIL watchdog: got err=%b after %0d want err=1 after %0d", w_wd_err, n, WD);
    end
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
